dma_program_loader: RTL and testbench

// - Routes the 16-bit CPU DMA stream (s_axis) into one of NUM_CH on-chip destinations: instruction

---
 rtl/loader_pkg.sv | 30 +++
 rtl/gpio_reg_strobe.sv | 55 +++++
 rtl/dma_program_loader.sv | 164 ++++++++++++++++
 tb/tb_dma_program_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: types and constants shared by dma_program_loader, gpio_reg_strobe,
// experiment_top_level and the bench.
//   - loader_state_e : transfer FSM state, encoding is visible in status_out[31:29]
//   - ERR_*          : error codes reported in status_out[28:26]
//   - ADDR_*_DEF     : default GPIO register addresses of the loader
//   - CTRL_*         : bit positions inside the control byte
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERROR  = 3'd3
    } loader_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_CH   = 3'd1;
    localparam logic [2:0] ERR_TOO_LONG = 3'd2;
    localparam logic [2:0] ERR_ABORTED  = 3'd3;

    localparam logic [15:0] ADDR_SEL_DEF    = 16'h0010;
    localparam logic [15:0] ADDR_LEN_LO_DEF = 16'h0011;
    localparam logic [15:0] ADDR_LEN_HI_DEF = 16'h0012;
    localparam logic [15:0] ADDR_CTRL_DEF   = 16'h0013;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_CLEAR = 2;

endpackage

// File: rtl/gpio_reg_strobe.sv
// gpio_reg_strobe: turns the packed GPIO bus into per-register write strobes.
// The w_clk bit is registered twice; a write strobe fires for one cycle on the
// 0->1 transition of the second registered copy, so the write takes effect on
// the third clock edge after w_clk rises. The host keeps addr/data steady while
// w_clk is high, so they are decoded directly from gpio_in.
//   clk, rst   : system clock, synchronous active-high reset
//   gpio_in    : [15:0] addr, [23:16] data, [24] w_clk
//   wr_stb     : one-hot strobe, bit r set when addr == REG_ADDRS[r*16 +: 16]
//   wr_data    : data byte accompanying the strobe
module gpio_reg_strobe #(
    parameter int unsigned              NUM_REGS  = 4,
    parameter logic [NUM_REGS*16-1:0]   REG_ADDRS = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         gpio_in,
    output logic [NUM_REGS-1:0] wr_stb,
    output logic [7:0]          wr_data
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic rise;

    always_comb begin
        sync1_d = gpio_in[24];
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    always_comb begin
        rise    = sync2_q & ~sync3_q;
        wr_data = gpio_in[23:16];
        wr_stb  = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (rise && (gpio_in[15:0] == REG_ADDRS[r*16 +: 16])) begin
                wr_stb[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_program_loader.sv
// dma_program_loader: routes the CPU DMA stream to one of NUM_CH destinations
// (0 instr FIFO, 1 beta FIFO, 2 out LUT, 3 in LUT) with a length-checked
// transfer, abort and error reporting, configured over the packed GPIO bus.
//   clk, rst       : system clock, synchronous active-high reset
//   gpio_in        : [15:0] addr, [23:16] data, [24] w_clk strobe
//   status_out     : [31:29] state, [28:26] err_code, [25:0] word count
//   s_axis_*       : DMA slave stream
//   m_axis_*       : per-channel master streams, channel c at [c*DATA_W +: DATA_W]
//   done_pulse     : one-cycle pulse after a transfer completes
module dma_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [15:0] ADDR_SEL    = ADDR_SEL_DEF,
    parameter logic [15:0] ADDR_LEN_LO = ADDR_LEN_LO_DEF,
    parameter logic [15:0] ADDR_LEN_HI = ADDR_LEN_HI_DEF,
    parameter logic [15:0] ADDR_CTRL   = ADDR_CTRL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              gpio_in,
    output logic [31:0]              status_out,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    output logic                     done_pulse
);

    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] MAX_LEN = 32'(2 ** DEPTH_LOG2);

    loader_state_e state_q, state_d;
    logic [3:0]    sel_q, sel_d;
    logic [15:0]   len_q, len_d;
    logic [25:0]   count_q, count_d;
    logic [2:0]    err_q, err_d;
    logic          done_q, done_d;

    logic [3:0]       wr_stb;
    logic [7:0]       wr_data;
    logic             ctrl_start, ctrl_abort, ctrl_clear;
    logic             abort_now, beat;
    logic [SEL_W-1:0] sel_idx;
    logic [25:0]      count_inc;

    // Strobe index order: 0 SEL, 1 LEN_LO, 2 LEN_HI, 3 CTRL.
    gpio_reg_strobe #(
        .NUM_REGS  (4),
        .REG_ADDRS ({ADDR_CTRL, ADDR_LEN_HI, ADDR_LEN_LO, ADDR_SEL})
    ) u_gpio (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .wr_stb  (wr_stb),
        .wr_data (wr_data)
    );

    always_comb begin
        ctrl_start = wr_stb[3] & wr_data[CTRL_START];
        ctrl_abort = wr_stb[3] & wr_data[CTRL_ABORT];
        ctrl_clear = wr_stb[3] & wr_data[CTRL_CLEAR];
        sel_idx    = sel_q[SEL_W-1:0];
        count_inc  = count_q + 26'd1;

        // An abort landing on a live beat suppresses the handshake on that
        // same cycle so the word is neither forwarded nor counted.
        abort_now     = (state_q == ST_STREAM) && ctrl_abort;
        m_axis_tdata  = {NUM_CH{s_axis_tdata}};
        m_axis_tvalid = '0;
        s_axis_tready = 1'b0;
        if ((state_q == ST_STREAM) && !abort_now) begin
            m_axis_tvalid[sel_idx] = s_axis_tvalid;
            s_axis_tready          = m_axis_tready[sel_idx];
        end
        beat = s_axis_tvalid && s_axis_tready;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort and clear both override a start in the same byte
                if (ctrl_start && !ctrl_abort && !ctrl_clear) begin
                    if (32'(sel_q) >= 32'(NUM_CH)) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_BAD_CH;
                    end else if (32'(len_q) > MAX_LEN) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TOO_LONG;
                    end else if (len_q == 16'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = '0;
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (abort_now) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_ABORTED;
                end else if (beat) begin
                    count_d = count_inc;
                    if (count_inc == 26'(len_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (ctrl_clear) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Configuration is frozen while a transfer is running.
        if (state_q != ST_STREAM) begin
            if (wr_stb[0]) sel_d        = wr_data[3:0];
            if (wr_stb[1]) len_d[7:0]   = wr_data;
            if (wr_stb[2]) len_d[15:8]  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        status_out = {state_q, err_q, count_q};
        done_pulse = done_q;
    end

endmodule

// File: tb/tb_dma_program_loader.sv
module tb_dma_program_loader;
    import loader_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       gpio_in;
    logic [31:0]       status_out;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [NCH*DW-1:0] m_tdata;
    logic [NCH-1:0]    m_tvalid;
    logic [NCH-1:0]    m_tready;
    logic              done_pulse;

    dma_program_loader #(
        .NUM_CH     (NCH),
        .DATA_W     (DW),
        .DEPTH_LOG2 (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .status_out    (status_out),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .done_pulse    (done_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: transfer state per the loader rules (0 idle, 1 stream, 2 done, 3 error)
    int m_state = 0, m_sel = 0, m_len = 0, m_count = 0, m_err = 0;
    bit m_done = 0;
    // Pending GPIO write: edges seen since w_clk rose, -1 when none
    int          wr_age = -1;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    // Source side
    int src_left = 0;
    int rdy_pct  = 100;
    int refill_n = 0;

    function automatic void apply_write();
        case (wr_addr)
            ADDR_SEL_DEF:    if (m_state != 1) m_sel = int'(wr_data[3:0]);
            ADDR_LEN_LO_DEF: if (m_state != 1) m_len = (m_len & 'hFF00) | int'(wr_data);
            ADDR_LEN_HI_DEF: if (m_state != 1) m_len = (m_len & 'h00FF) | (int'(wr_data) << 8);
            ADDR_CTRL_DEF: begin
                if (m_state == 1) begin
                    if (wr_data[1]) begin m_state = 3; m_err = 3; end
                end else if (m_state == 3) begin
                    if (wr_data[2]) begin m_state = 0; m_err = 0; end
                end else if (wr_data[0] && !wr_data[1] && !wr_data[2]) begin
                    if (m_sel >= NCH)      begin m_state = 3; m_err = 1; end
                    else if (m_len > 1024) begin m_state = 3; m_err = 2; end
                    else if (m_len == 0)   begin m_state = 2; m_done = 1; end
                    else                   begin m_count = 0; m_state = 1; end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic step();
        bit          wr_now, strm, abort_now, rdy, beat;
        logic [NCH-1:0] exp_v;
        @(negedge clk);
        wr_now    = (wr_age == 2);
        strm      = (m_state == 1);
        abort_now = wr_now && (wr_addr == ADDR_CTRL_DEF) && wr_data[1] && strm;
        rdy       = strm && !abort_now && m_tready[m_sel[1:0]];
        exp_v     = '0;
        if (strm && !abort_now && s_tvalid) exp_v[m_sel[1:0]] = 1'b1;
        check("s_tready", 64'(s_tready), 64'(rdy));
        check("m_tvalid", 64'(m_tvalid), 64'(exp_v));
        if (strm) check("m_tdata", m_tdata, {NCH{s_tdata}});
        check("status", 64'(status_out), 64'({m_state[2:0], m_err[2:0], m_count[25:0]}));
        check("done_pulse", 64'(done_pulse), 64'(m_done));
        beat = rdy && s_tvalid;
        @(posedge clk);
        m_done = 0;
        if (rst) begin
            m_state = 0; m_sel = 0; m_len = 0; m_count = 0; m_err = 0;
        end else begin
            if (beat) begin
                m_count++;
                if (m_count == m_len) begin m_state = 2; m_done = 1; end
            end
            if (wr_now) apply_write();
        end
        if (beat && src_left > 0) src_left--;
        if (wr_age >= 0) wr_age++;
        #1;
        for (int c = 0; c < NCH; c++) m_tready[c] = ($urandom_range(99) < rdy_pct);
        if (!s_tvalid || beat) begin
            s_tvalid = (src_left > 0) && ($urandom_range(3) != 0);
            s_tdata  = DW'($urandom);
        end
        if (refill_n > 0 && wr_age == 2) begin
            src_left = refill_n;
            refill_n = 0;
            s_tvalid = 1'b1;
            s_tdata  = DW'($urandom);
            m_tready = '1;
        end
    endtask

    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        gpio_in = {7'b0, 1'b1, d, a};
        wr_age  = 0;
        repeat (4) step();
        gpio_in[24] = 1'b0;
        wr_age      = -1;
        repeat (3) step();
    endtask

    task automatic cfg(input int sel, input int len);
        gpio_write(ADDR_SEL_DEF, 8'(sel));
        gpio_write(ADDR_LEN_LO_DEF, 8'(len));
        gpio_write(ADDR_LEN_HI_DEF, 8'(len >> 8));
        src_left = len + 4;
    endtask

    task automatic run_to_end();
        for (int i = 0; i < 8000 && m_state == 1; i++) step();
        if (m_state == 1) check("xfer_timeout", 64'(status_out[31:29]), 64'(3'd2));
        repeat (2) step();
    endtask

    initial begin
        int len, sel, k;
        rst = 1'b1; gpio_in = '0; s_tdata = '0; s_tvalid = 1'b0; m_tready = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // basic transfer on ch0, all ready
        rdy_pct = 100;
        cfg(0, 5);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        run_to_end();
        check("t1_state", 64'(status_out[31:29]), 64'(3'd2));
        check("t1_count", 64'(status_out[25:0]), 64'(26'd5));

        // ch1 with throttled ready
        rdy_pct = 50;
        cfg(1, 4);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        run_to_end();

        // too long, bad channel, zero length, unmatched address
        cfg(0, 1025);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        check("too_long_err", 64'(status_out[28:26]), 64'(ERR_TOO_LONG));
        gpio_write(ADDR_CTRL_DEF, 8'h04);
        cfg(5, 3);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        check("bad_ch_err", 64'(status_out[28:26]), 64'(ERR_BAD_CH));
        gpio_write(ADDR_CTRL_DEF, 8'h04);
        cfg(0, 0);
        gpio_write(16'h0020, 8'h01);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        check("zero_len_state", 64'(status_out[31:29]), 64'(3'd2));

        // abort after exactly 3 of 8 words, with a word in flight on the abort edge
        s_tvalid = 1'b0;
        rdy_pct  = 100;
        cfg(2, 8);
        src_left = 3;
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        for (int i = 0; i < 200 && m_count < 3; i++) step();
        refill_n = 5;
        gpio_write(ADDR_CTRL_DEF, 8'h02);
        check("abort_err", 64'(status_out[28:26]), 64'(ERR_ABORTED));
        check("abort_count", 64'(status_out[25:0]), 64'(26'd3));
        gpio_write(ADDR_CTRL_DEF, 8'h04);

        // start+abort and start+clear in idle start nothing
        cfg(0, 4);
        gpio_write(ADDR_CTRL_DEF, 8'h03);
        gpio_write(ADDR_CTRL_DEF, 8'h05);
        check("combo_idle", 64'(status_out[31:29]), 64'(3'd0));

        // reset mid-stream
        cfg(3, 20);
        gpio_write(ADDR_CTRL_DEF, 8'h01);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            rdy_pct = $urandom_range(100, 40);
            sel = $urandom_range(4);
            k   = $urandom_range(9);
            len = (k == 0) ? 0 : (k == 1) ? 1024 : (k == 2) ? 1025 : $urandom_range(12, 1);
            cfg(sel, len);
            gpio_write(ADDR_CTRL_DEF, 8'h01);
            repeat ($urandom_range(6)) step();
            k = $urandom_range(3);
            if (k == 0) gpio_write(ADDR_CTRL_DEF, 8'(2 | $urandom_range(1)));
            else if (k == 1) gpio_write(ADDR_SEL_DEF, 8'($urandom_range(3)));
            else if (k == 2) gpio_write(ADDR_LEN_LO_DEF, 8'($urandom));
            run_to_end();
            if (m_state == 3) gpio_write(ADDR_CTRL_DEF, 8'h04);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
